// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic {RUN, MEM_WAIT} hz_state_t;

  localparam int unsigned WAIT_MAX_DEF = 15;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that saturates at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hold/flush generation for the 5-stage pipeline: load-use, taken branch,
// and data-memory wait handling, plus stall/flush performance counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W    = 5,
  parameter int unsigned WAIT_MAX = WAIT_MAX_DEF,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] rs1_d,
  input  logic [REG_W-1:0] rs2_d,
  input  logic             rs1_used_d,
  input  logic             rs2_used_d,
  input  logic [REG_W-1:0] rd_e,
  input  logic             mem_read_e,
  input  logic             pc_src_e,
  input  logic             mem_access_m,
  input  logic             mem_ready_m,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             flush_d,
  output logic             flush_e,
  output logic             flush_w,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned WAIT_W = $clog2(WAIT_MAX + 1);

  hz_state_t         state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_stall;
  logic              lu;

  // Hazard decode; a memory stall freezes everything, so a resolved branch
  // stays in EX and is acted on once memory releases.
  always_comb begin
    mem_stall = mem_access_m & ~mem_ready_m;
    lu        = mem_read_e & (rd_e != '0) &
                ((rs1_used_d & (rs1_d == rd_e)) | (rs2_used_d & (rs2_d == rd_e)));
    stall_f   = 1'b0;
    stall_d   = 1'b0;
    stall_e   = 1'b0;
    stall_m   = 1'b0;
    flush_d   = 1'b0;
    flush_e   = 1'b0;
    flush_w   = 1'b0;
    if (mem_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (pc_src_e) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (lu) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  // Memory-wait tracking; timeout is sticky until reset, FSM keeps waiting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          wait_cnt <= '0;
          if (mem_stall) state <= MEM_WAIT;
        end
        MEM_WAIT: begin
          if (mem_ready_m) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_W'(WAIT_MAX)) begin
            mem_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_f),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_d | flush_e),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus random traffic checked
// every cycle against a behavioural model; a 4-bit-counter copy covers saturation.
module tb_hazard_ctrl;

  localparam int unsigned REG_W    = 5;
  localparam int unsigned WAIT_MAX = 15;
  localparam int unsigned CNT_W    = 32;
  localparam int unsigned CNT_S    = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [REG_W-1:0] rs1_d, rs2_d, rd_e;
  logic             rs1_used_d, rs2_used_d, mem_read_e, pc_src_e;
  logic             mem_access_m, mem_ready_m;

  logic             stall_f_a, stall_d_a, stall_e_a, stall_m_a;
  logic             flush_d_a, flush_e_a, flush_w_a, mem_timeout_a;
  logic [CNT_W-1:0] stall_cnt_a, flush_cnt_a;
  logic             stall_f_b, stall_d_b, stall_e_b, stall_m_b;
  logic             flush_d_b, flush_e_b, flush_w_b, mem_timeout_b;
  logic [CNT_S-1:0] stall_cnt_b, flush_cnt_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_W(REG_W), .WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut_a (
    .clk(clk), .reset(reset), .rs1_d(rs1_d), .rs2_d(rs2_d),
    .rs1_used_d(rs1_used_d), .rs2_used_d(rs2_used_d), .rd_e(rd_e),
    .mem_read_e(mem_read_e), .pc_src_e(pc_src_e), .mem_access_m(mem_access_m),
    .mem_ready_m(mem_ready_m), .stall_f(stall_f_a), .stall_d(stall_d_a),
    .stall_e(stall_e_a), .stall_m(stall_m_a), .flush_d(flush_d_a),
    .flush_e(flush_e_a), .flush_w(flush_w_a), .mem_timeout(mem_timeout_a),
    .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a)
  );

  hazard_ctrl #(.REG_W(REG_W), .WAIT_MAX(WAIT_MAX), .CNT_W(CNT_S)) dut_b (
    .clk(clk), .reset(reset), .rs1_d(rs1_d), .rs2_d(rs2_d),
    .rs1_used_d(rs1_used_d), .rs2_used_d(rs2_used_d), .rd_e(rd_e),
    .mem_read_e(mem_read_e), .pc_src_e(pc_src_e), .mem_access_m(mem_access_m),
    .mem_ready_m(mem_ready_m), .stall_f(stall_f_b), .stall_d(stall_d_b),
    .stall_e(stall_e_b), .stall_m(stall_m_b), .flush_d(flush_d_b),
    .flush_e(flush_e_b), .flush_w(flush_w_b), .mem_timeout(mem_timeout_b),
    .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b)
  );

  // ---------------- behavioural model ----------------
  bit     m_in_wait;
  int     m_wait_n;
  bit     m_timeout;
  longint m_stall_n;
  longint m_flush_n;

  // Expected {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w}
  function automatic logic [6:0] exp_ctrl();
    bit not_ready;
    bit hit;
    not_ready = mem_access_m && !mem_ready_m;
    hit = mem_read_e && (rd_e != 0) &&
          ((rs1_used_d && rs1_d == rd_e) || (rs2_used_d && rs2_d == rd_e));
    if (not_ready) return 7'b1111001;
    if (pc_src_e)  return 7'b0000110;
    if (hit)       return 7'b1100010;
    return 7'b0000000;
  endfunction

  function automatic longint sat(longint v, int w);
    longint mx;
    mx = (longint'(1) <<< w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  always @(posedge clk or posedge reset) begin : model
    logic [6:0] e;
    if (reset) begin
      m_in_wait = 1'b0;
      m_wait_n  = 0;
      m_timeout = 1'b0;
      m_stall_n = 0;
      m_flush_n = 0;
    end else begin
      e = exp_ctrl();
      if (e[6]) m_stall_n++;
      if (e[2] || e[1]) m_flush_n++;
      if (!m_in_wait) begin
        if (mem_access_m && !mem_ready_m) begin
          m_in_wait = 1'b1;
          m_wait_n  = 0;
        end
      end else if (mem_ready_m) begin
        m_in_wait = 1'b0;
      end else begin
        m_wait_n++;
        if (m_wait_n > WAIT_MAX) m_timeout = 1'b1;
      end
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge
  always @(negedge clk) begin : compare
    logic [6:0] e;
    e = exp_ctrl();
    check("ctrl_a", 64'({stall_f_a, stall_d_a, stall_e_a, stall_m_a, flush_d_a, flush_e_a, flush_w_a}), 64'(e));
    check("ctrl_b", 64'({stall_f_b, stall_d_b, stall_e_b, stall_m_b, flush_d_b, flush_e_b, flush_w_b}), 64'(e));
    check("timeout_a", 64'(mem_timeout_a), 64'(m_timeout));
    check("timeout_b", 64'(mem_timeout_b), 64'(m_timeout));
    check("stall_cnt_a", 64'(stall_cnt_a), 64'(sat(m_stall_n, CNT_W)));
    check("flush_cnt_a", 64'(flush_cnt_a), 64'(sat(m_flush_n, CNT_W)));
    check("stall_cnt_b", 64'(stall_cnt_b), 64'(sat(m_stall_n, CNT_S)));
    check("flush_cnt_b", 64'(flush_cnt_b), 64'(sat(m_flush_n, CNT_S)));
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    rs1_d = '0; rs2_d = '0; rd_e = '0;
    rs1_used_d = 1'b0; rs2_used_d = 1'b0; mem_read_e = 1'b0;
    pc_src_e = 1'b0; mem_access_m = 1'b0; mem_ready_m = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic load_use();
    mem_read_e = 1'b1; rd_e = 5'd5; rs1_d = 5'd5; rs1_used_d = 1'b1;
  endtask

  initial begin
    idle();
    #1;
    check("rst_ctrl", 64'({stall_f_a, stall_d_a, stall_e_a, stall_m_a, flush_d_a, flush_e_a, flush_w_a}), 64'd0);
    check("rst_cnt", 64'({stall_cnt_a, flush_cnt_a}), 64'd0);
    tick(2);
    reset = 1'b0;

    // Load-use: one bubble
    load_use();
    #1;
    check("lu_stall", 64'({stall_f_a, stall_d_a, stall_e_a, stall_m_a}), 64'b1100);
    check("lu_flush", 64'({flush_d_a, flush_e_a, flush_w_a}), 64'b010);
    tick(1);
    idle();
    #1;
    check("lu_release", 64'(stall_f_a), 64'd0);
    check("lu_stall_cnt", 64'(stall_cnt_a), 64'd1);

    // rd_e == 0 and unused rs2 never stall
    mem_read_e = 1'b1; rd_e = '0; rs1_d = '0; rs1_used_d = 1'b1;
    #1;
    check("rd0_no_stall", 64'(stall_f_a), 64'd0);
    rd_e = 5'd7; rs1_d = 5'd3; rs2_d = 5'd7; rs2_used_d = 1'b0;
    #1;
    check("rs2_unused", 64'(stall_f_a), 64'd0);
    tick(1);

    // Branch overrides load-use
    do_reset();
    load_use();
    pc_src_e = 1'b1;
    #1;
    check("br_over_lu", 64'({flush_d_a, flush_e_a, stall_f_a}), 64'b110);
    tick(1);
    idle();
    #1;
    check("br_flush_cnt", 64'(flush_cnt_a), 64'd1);
    check("br_stall_cnt", 64'(stall_cnt_a), 64'd0);

    // Three-cycle memory wait
    do_reset();
    mem_access_m = 1'b1; mem_ready_m = 1'b0;
    #1;
    check("mw_freeze", 64'({stall_f_a, stall_d_a, stall_e_a, stall_m_a, flush_w_a}), 64'b11111);
    tick(3);
    mem_ready_m = 1'b1;
    #1;
    check("mw_release", 64'({stall_f_a, stall_d_a, stall_e_a, stall_m_a, flush_w_a}), 64'd0);
    tick(1);
    idle();
    #1;
    check("mw_stall_cnt", 64'(stall_cnt_a), 64'd3);

    // Timeout boundary: set on the 17th not-ready cycle, sticky after
    do_reset();
    mem_access_m = 1'b1; mem_ready_m = 1'b0;
    tick(16);
    check("to_not_yet", 64'(mem_timeout_a), 64'd0);
    tick(1);
    check("to_set", 64'(mem_timeout_a), 64'd1);
    mem_ready_m = 1'b1;
    tick(1);
    idle();
    tick(1);
    check("to_sticky", 64'(mem_timeout_a), 64'd1);

    // Reset mid-wait
    do_reset();
    mem_access_m = 1'b1; mem_ready_m = 1'b0;
    tick(17);
    check("rw_to_set", 64'(mem_timeout_a), 64'd1);
    idle();
    reset = 1'b1;
    #1;
    check("rw_ctrl", 64'({stall_f_a, stall_d_a, stall_e_a, stall_m_a, flush_d_a, flush_e_a, flush_w_a}), 64'd0);
    check("rw_cleared", 64'({stall_cnt_a, flush_cnt_a, 31'd0, mem_timeout_a}), 64'd0);
    tick(1);
    reset = 1'b0;
    mem_access_m = 1'b1; mem_ready_m = 1'b1;
    tick(1);
    idle();
    tick(1);
    check("rw_run", 64'(stall_cnt_a), 64'd0);

    // Narrow counter saturation
    do_reset();
    load_use();
    tick(20);
    idle();
    #1;
    check("sat_small", 64'(stall_cnt_b), 64'd15);
    check("sat_wide", 64'(stall_cnt_a), 64'd20);

    // Random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        idle();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
      end
      rs1_d        = REG_W'($urandom_range(0, 3));
      rs2_d        = REG_W'($urandom_range(0, 3));
      rd_e         = REG_W'($urandom_range(0, 3));
      rs1_used_d   = 1'($urandom_range(0, 1));
      rs2_used_d   = 1'($urandom_range(0, 1));
      mem_read_e   = ($urandom_range(0, 2) == 0);
      pc_src_e     = ($urandom_range(0, 6) == 0);
      mem_access_m = ($urandom_range(0, 3) == 0) || (i % 500 > 470);
      mem_ready_m  = ($urandom_range(0, 9) < 4) && (i % 500 <= 470);
      tick(1);
    end
    idle();
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage core. It generates the hold and flush controls for the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It detects load-use hazards and taken branches/jumps, and runs a memory-wait state machine that freezes the pipeline while data memory is not ready. It also keeps saturating performance counters for stall and flush cycles.

## Interface
Parameters:
- REG_W, 5, register-index width
- WAIT_MAX, 15, maximum memory-wait cycles before the timeout flag sets
- CNT_W, 32, performance-counter width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- rs1_d, rs2_d  in  REG_W  source registers of the instruction in ID
- rs1_used_d, rs2_used_d  in  1  the ID instruction actually reads rs1/rs2
- rd_e  in  REG_W  destination register of the instruction in EX
- mem_read_e  in  1  the EX instruction is a load
- pc_src_e  in  1  branch taken or jump resolved in EX
- mem_access_m  in  1  the MEM instruction performs a load or store
- mem_ready_m  in  1  data memory completes the access this cycle
- stall_f  out  1  PC register holds; connects directly to the PC flop's hold input (1 = hold)
- stall_d, stall_e, stall_m  out  1  IF/ID, ID/EX, EX/MEM hold
- flush_d, flush_e, flush_w  out  1  IF/ID, ID/EX, MEM/WB load a bubble
- mem_timeout  out  1  sticky; memory wait exceeded WAIT_MAX
- stall_cnt, flush_cnt  out  CNT_W  performance counters

## Operation
- FSM states: RUN, MEM_WAIT.
  - RUN → MEM_WAIT when mem_access_m & !mem_ready_m.
  - MEM_WAIT → RUN on mem_ready_m.
- Memory-stall term: mem_stall = mem_access_m & !mem_ready_m. It is evaluated combinationally in both states, so the stall applies in the same cycle it is detected.
- Load-use term: lu = mem_read_e & (rd_e != 0) & ((rs1_used_d & rs1_d == rd_e) | (rs2_used_d & rs2_d == rd_e)).
- Output priority, highest first:
  1. mem_stall: stall_f = stall_d = stall_e = stall_m = 1; flush_w = 1; flush_d = flush_e = 0. A pending pc_src_e stays frozen in EX and is acted on after release.
  2. pc_src_e: flush_d = flush_e = 1; no stalls. This overrides lu because the dependent instruction is squashed.
  3. lu: stall_f = stall_d = 1; flush_e = 1.
  4. Otherwise all controls are 0.
- wait_cnt (internal, width sized for WAIT_MAX):
  - Cleared in RUN.
  - Increments each MEM_WAIT cycle, saturating at WAIT_MAX.
  - mem_timeout sets when a wait cycle occurs with wait_cnt == WAIT_MAX. It clears only on reset. The FSM keeps waiting.
- stall_cnt increments on each cycle with stall_f = 1. flush_cnt increments on each cycle with flush_d | flush_e. Both saturate at all-ones and never wrap.

## Timing
- Reset values:
  - state = RUN; wait_cnt, stall_cnt, flush_cnt = 0; mem_timeout = 0.
  - All stall/flush outputs are 0 while reset is held. This follows from the combinational terms, so the bench must drive inputs low.
- Hazard outputs are combinational, with zero-cycle latency from inputs. Counters and mem_timeout update on the next rising edge.
- A load-use hazard produces exactly one bubble cycle: the next cycle has the load in MEM and lu deasserts.
- Release: in the cycle mem_ready_m = 1, all stalls drop and the pipeline advances on that edge.
- Reset asserted mid-wait returns to RUN immediately and clears the counters and mem_timeout.
- mem_ready_m without mem_access_m is ignored.

## Structure
- hazard_pkg holds:
  - the state enum typedef, hz_state_t {RUN, MEM_WAIT};
  - the localparam for the default WAIT_MAX.
- Sub-module sat_counter (parameter W; inputs clk, reset, inc; output count) is instantiated for stall_cnt and flush_cnt.
- Hazard decode is one combinational always_comb. The FSM and wait_cnt sit in one always_ff with asynchronous reset.

## Test plan
- Load-use: mem_read_e=1, rd_e=5, rs1_d=5, rs1_used_d=1 → stall_f=stall_d=flush_e=1 for one cycle; stall_cnt=1 afterwards.
- rd_e=0 with a matching rs1_d=0, or rs2_used_d=0 with a match on rs2 → no stall.
- Load-use together with pc_src_e=1 → flush_d=flush_e=1, stall_f=0; flush_cnt increments by 1.
- mem_access_m=1 with mem_ready_m=0 for 3 cycles, then 1 → all four stalls and flush_w high for 3 cycles; state returns to RUN; stall_cnt=3.
- Memory not ready for WAIT_MAX+2 cycles (17 with default WAIT_MAX=15) → mem_timeout=1 and stays 1 after mem_ready_m. Reset asserted mid-wait → all outputs 0 and state RUN.
- Preload stall_cnt near all-ones with CNT_W=4 → the counter holds at 15.
